// File: rtl/escalonador_elevador.sv
// SCAN elevator call scheduler: latches floor calls, flags calls above/below the cabin
// and sequences idle / up / down / door-open with a reloadable door timer.
`timescale 1ns/1ps
module escalonador_elevador #(
  parameter int N_ANDARES = 16,
  parameter int T_PORTA   = 4,
  parameter int AW        = (N_ANDARES > 2) ? $clog2(N_ANDARES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_ANDARES-1:0] botao,
  input  logic [AW-1:0]        andar,
  input  logic                 andar_valido,
  output logic [N_ANDARES-1:0] pendentes,
  output logic                 subida,
  output logic                 descida,
  output logic                 motor_sobe,
  output logic                 motor_desce,
  output logic                 porta_aberta,
  output logic [1:0]           estado
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    SUBINDO  = 2'd1,
    DESCENDO = 2'd2,
    PORTA    = 2'd3
  } estado_t;

  localparam int TW = (T_PORTA > 1) ? $clog2(T_PORTA) : 1;
  localparam logic [TW-1:0] T_RELOAD = TW'(T_PORTA - 1);

  estado_t              estado_q;
  estado_t              estado_prox;
  logic [TW-1:0]        timer;
  logic                 ultima_dir;
  logic                 em_faixa;
  logic                 aqui;
  logic                 press_aqui;
  logic [N_ANDARES-1:0] sel;
  logic [N_ANDARES-1:0] limpa;

  assign em_faixa = (32'(andar) < N_ANDARES);
  assign estado   = estado_q;

  // Floor decode: an out-of-range floor selects nothing, so no call is seen anywhere.
  always_comb begin
    sel     = '0;
    subida  = 1'b0;
    descida = 1'b0;
    for (int i = 0; i < N_ANDARES; i++) begin
      if (em_faixa) begin
        if (i == int'(andar)) sel[i] = 1'b1;
        if (i > int'(andar))  subida  = subida  | pendentes[i];
        if (i < int'(andar))  descida = descida | pendentes[i];
      end
    end
    aqui       = |(pendentes & sel);
    press_aqui = |(botao & sel);
  end

  always_comb begin
    estado_prox = estado_q;
    if (em_faixa) begin
      case (estado_q)
        OCIOSO: begin
          if (andar_valido && aqui) estado_prox = PORTA;
          else if (subida)          estado_prox = SUBINDO;
          else if (descida)         estado_prox = DESCENDO;
        end
        SUBINDO: begin
          if (andar_valido && aqui)         estado_prox = PORTA;
          else if (andar_valido && !subida) estado_prox = OCIOSO;
        end
        DESCENDO: begin
          if (andar_valido && aqui)          estado_prox = PORTA;
          else if (andar_valido && !descida) estado_prox = OCIOSO;
        end
        PORTA: begin
          // A press at this floor keeps the door open rather than registering a call.
          if (!press_aqui && timer == '0) begin
            if (ultima_dir && subida)        estado_prox = SUBINDO;
            else if (!ultima_dir && descida) estado_prox = DESCENDO;
            else if (subida)                 estado_prox = SUBINDO;
            else if (descida)                estado_prox = DESCENDO;
            else                             estado_prox = OCIOSO;
          end
        end
        default: estado_prox = OCIOSO;
      endcase
    end
  end

  assign limpa = (estado_prox == PORTA || estado_q == PORTA) ? sel : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pendentes    <= '0;
      estado_q     <= OCIOSO;
      timer        <= '0;
      ultima_dir   <= 1'b1;
      motor_sobe   <= 1'b0;
      motor_desce  <= 1'b0;
      porta_aberta <= 1'b0;
    end else begin
      pendentes    <= (pendentes | botao) & ~limpa;
      estado_q     <= estado_prox;
      motor_sobe   <= (estado_prox == SUBINDO);
      motor_desce  <= (estado_prox == DESCENDO);
      porta_aberta <= (estado_prox == PORTA);
      if (estado_prox == SUBINDO && estado_q != SUBINDO)
        ultima_dir <= 1'b1;
      else if (estado_prox == DESCENDO && estado_q != DESCENDO)
        ultima_dir <= 1'b0;
      if (estado_prox == PORTA) begin
        if (estado_q != PORTA || press_aqui)
          timer <= T_RELOAD;
        else if (em_faixa && timer != '0)
          timer <= timer - TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_escalonador_elevador.sv
// Directed bench for escalonador_elevador: 16-floor instance plus a 10-floor instance
// for the out-of-range floor case; expectations queued at stimulus, popped at sampling.
`timescale 1ns/1ps
module tb_escalonador_elevador;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] botao;
  logic [3:0]  andar;
  logic        andar_valido;
  logic [15:0] pendentes;
  logic        subida, descida, motor_sobe, motor_desce, porta_aberta;
  logic [1:0]  estado;

  logic        b_rst_n;
  logic [9:0]  b_botao;
  logic [3:0]  b_andar;
  logic        b_andar_valido;
  logic [9:0]  b_pendentes;
  logic        b_subida, b_descida, b_motor_sobe, b_motor_desce, b_porta_aberta;
  logic [1:0]  b_estado;

  escalonador_elevador #(.N_ANDARES(16), .T_PORTA(4)) dut (
    .clk(clk), .rst_n(rst_n), .botao(botao), .andar(andar), .andar_valido(andar_valido),
    .pendentes(pendentes), .subida(subida), .descida(descida), .motor_sobe(motor_sobe),
    .motor_desce(motor_desce), .porta_aberta(porta_aberta), .estado(estado)
  );

  escalonador_elevador #(.N_ANDARES(10), .T_PORTA(4)) dut10 (
    .clk(clk), .rst_n(b_rst_n), .botao(b_botao), .andar(b_andar), .andar_valido(b_andar_valido),
    .pendentes(b_pendentes), .subida(b_subida), .descida(b_descida), .motor_sobe(b_motor_sobe),
    .motor_desce(b_motor_desce), .porta_aberta(b_porta_aberta), .estado(b_estado)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic expect_v(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty observed=%0h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called on the first door-open sample; checks the remaining dwell and the exit state.
  task automatic dwell(input string t, input logic [1:0] next_st);
    for (int i = 0; i < 3; i++) begin
      expect_v({t, "_porta"}, 1);
      tick();
      chk(porta_aberta);
    end
    expect_v({t, "_next"}, next_st);
    expect_v({t, "_closed"}, 0);
    tick();
    chk(estado);
    chk(porta_aberta);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; botao = '0; andar = '0; andar_valido = 1'b1;
    b_rst_n = 1'b0; b_botao = '0; b_andar = '0; b_andar_valido = 1'b1;

    // Reset values
    expect_v("rst_pend", 0);
    expect_v("rst_estado", 0);
    expect_v("rst_drives", 0);
    expect_v("rst_dirs", 0);
    tick(); tick();
    chk(pendentes);
    chk(estado);
    chk({motor_sobe, motor_desce, porta_aberta});
    chk({subida, descida});

    // Enter PORTA at floor 2 with calls 4..7 pending, then reset mid-operation
    rst_n = 1'b1; andar = 4'd2; botao = 16'h00F4;
    tick();
    botao = '0;
    expect_v("setup_porta", 3);
    expect_v("setup_pend", 16'h00F0);
    tick();
    chk(estado);
    chk(pendentes);
    rst_n = 1'b0;
    expect_v("midrst_pend", 0);
    expect_v("midrst_estado", 0);
    expect_v("midrst_drives", 0);
    tick(); tick();
    chk(pendentes);
    chk(estado);
    chk({motor_sobe, motor_desce, porta_aberta});
    rst_n = 1'b1;

    // Up trip: call latency, motor latency, arrival, door dwell
    andar = 4'd2; botao = 16'h0200;
    expect_v("lat_pend", 16'h0200);
    expect_v("lat_subida", 1);
    expect_v("lat_msobe_early", 0);
    tick();
    botao = '0;
    chk(pendentes);
    chk(subida);
    chk(motor_sobe);
    expect_v("lat_msobe", 1);
    expect_v("lat_estado", 1);
    tick();
    chk(motor_sobe);
    chk(estado);
    andar = 4'd9;
    expect_v("arr_estado", 3);
    expect_v("arr_pend", 0);
    expect_v("arr_porta", 1);
    tick();
    chk(estado);
    chk(pendentes);
    chk(porta_aberta);
    dwell("up_dwell", 2'd0);

    // SCAN order: going up at 5 with calls at 8 and 1
    andar = 4'd5; botao = 16'h0100;
    tick();
    botao = '0;
    expect_v("scan_up", 1);
    tick();
    chk(estado);
    botao = 16'h0002;
    expect_v("scan_dirs", 2'b11);
    expect_v("scan_still_up", 1);
    tick();
    botao = '0;
    chk({subida, descida});
    chk(estado);
    andar = 4'd8;
    expect_v("scan_stop8", 3);
    expect_v("scan_pend8", 16'h0002);
    tick();
    chk(estado);
    chk(pendentes);
    dwell("scan_dwell8", 2'd2);
    expect_v("scan_mdesce", 1);
    chk(motor_desce);
    andar = 4'd1;
    expect_v("scan_stop1", 3);
    expect_v("scan_pend1", 0);
    tick();
    chk(estado);
    chk(pendentes);
    dwell("scan_dwell1", 2'd0);

    // Door reload: hold the current-floor button while the door is open
    andar = 4'd3; botao = 16'h0008;
    tick();
    botao = '0;
    expect_v("rl_entry", 3);
    tick();
    chk(estado);
    botao = 16'h0008;
    for (int i = 0; i < 6; i++) begin
      expect_v("rl_porta", 1);
      expect_v("rl_pend3", 0);
      tick();
      chk(porta_aberta);
      chk(pendentes[3]);
    end
    botao = '0;
    dwell("rl_after", 2'd0);

    // Overshoot guard: only call at 6, cabin reported at 7
    botao = 16'h0040;
    tick();
    botao = '0;
    expect_v("os_up", 1);
    tick();
    chk(estado);
    andar = 4'd7;
    expect_v("os_dirs", 2'b01);
    #1;
    chk({subida, descida});
    expect_v("os_idle", 0);
    expect_v("os_msobe", 0);
    tick();
    chk(estado);
    chk(motor_sobe);

    // Calls above and below while idle: up wins
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; andar = 4'd5; botao = 16'h0102;
    tick();
    botao = '0;
    expect_v("tie_up", 1);
    tick();
    chk(estado);

    // Out-of-range floor on the 10-floor instance: state held, no direction flags
    b_rst_n = 1'b1; b_andar = 4'd2; b_botao = 10'h200;
    tick();
    b_botao = '0;
    expect_v("oor_up", 1);
    tick();
    chk(b_estado);
    b_andar = 4'd12; b_botao = 10'h3FF;
    tick();
    b_botao = '0;
    for (int i = 0; i < 5; i++) begin
      expect_v("oor_dirs", 0);
      expect_v("oor_estado", 1);
      expect_v("oor_pend", 10'h3FF);
      tick();
      chk({b_subida, b_descida});
      chk(b_estado);
      chk(b_pendentes);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
